// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense path: channel geometry,
// FSM states, rejection codes and the small helpers used by the datapath.
package vend_pkg;

    localparam int NUM_CH  = 8;
    localparam int STOCK_W = 4;
    localparam int CH_W    = 3;
    localparam int PRICE_W = 8;

    localparam logic [NUM_CH*PRICE_W-1:0] DEFAULT_PRICES = 64'h0807060504030201;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CHECK       = 3'd1,
        ST_DISPENSE    = 3'd2,
        ST_REPORT_DONE = 3'd3,
        ST_REPORT_FAIL = 3'd4
    } state_e;

    localparam logic [1:0] FAIL_NONE      = 2'b00;
    localparam logic [1:0] FAIL_SOLD_OUT  = 2'b01;
    localparam logic [1:0] FAIL_NO_CREDIT = 2'b10;
    localparam logic [1:0] FAIL_BOTH      = 2'b11;

    // Net stock after an optional single-unit sale and an optional restock, clamped at full scale.
    function automatic logic [STOCK_W-1:0] sat_update(input logic [STOCK_W-1:0] stock,
                                                       input logic               dec,
                                                       input logic [STOCK_W-1:0] qty);
        logic [STOCK_W:0] sum;
        sum = {1'b0, stock} + {1'b0, qty} - {{STOCK_W{1'b0}}, dec};
        if (sum > {1'b0, {STOCK_W{1'b1}}}) begin
            return {STOCK_W{1'b1}};
        end else begin
            return sum[STOCK_W-1:0];
        end
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] r;
        r     = {NUM_CH{1'b0}};
        r[ch] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/stock_bank.sv
// Per-channel saturating stock counters with a sale-decrement port, a restock
// port, and two read ports (display query and the dispenser's stock check).
module stock_bank
    import vend_pkg::*;
#(
    parameter int INIT_STOCK = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid,
    input  logic [CH_W-1:0]    dec_channel,
    input  logic               restock_valid,
    input  logic [CH_W-1:0]    restock_channel,
    input  logic [STOCK_W-1:0] restock_qty,
    input  logic [CH_W-1:0]    query_channel,
    input  logic [CH_W-1:0]    check_channel,
    output logic [STOCK_W-1:0] query_stock,
    output logic [STOCK_W-1:0] check_stock
);

    logic [STOCK_W-1:0] stock_q [NUM_CH];

    // A sale and a restock on the same channel in one cycle combine into one update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                stock_q[i] <= sat_update(
                    stock_q[i],
                    dec_valid && (dec_channel == CH_W'(i)) && (stock_q[i] != {STOCK_W{1'b0}}),
                    (restock_valid && (restock_channel == CH_W'(i))) ? restock_qty : {STOCK_W{1'b0}});
            end
        end
    end

    assign query_stock = stock_q[query_channel];
    assign check_stock = stock_q[check_channel];

endmodule

// File: rtl/channel_dispenser.sv
// Buy-request consumer: checks stock and credit for the requested channel,
// runs that channel's motor for a fixed time, and reports done/fail and charge.
module channel_dispenser
    import vend_pkg::*;
#(
    parameter int                          INIT_STOCK   = 5,
    parameter logic [NUM_CH*PRICE_W-1:0]   PRICES       = DEFAULT_PRICES,
    parameter int                          MOTOR_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               buy_valid,
    input  logic [CH_W-1:0]    buy_channel,
    input  logic [PRICE_W-1:0] credit,
    input  logic               restock_valid,
    input  logic [CH_W-1:0]    restock_channel,
    input  logic [STOCK_W-1:0] restock_qty,
    input  logic [CH_W-1:0]    query_channel,
    output logic [STOCK_W-1:0] query_stock,
    output logic               busy,
    output logic [NUM_CH-1:0]  motor_en,
    output logic               done,
    output logic               fail,
    output logic [1:0]         fail_code,
    output logic [PRICE_W-1:0] charge
);

    localparam int CNT_W = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;

    state_e             state_q;
    logic [CH_W-1:0]    ch_q;
    logic [PRICE_W-1:0] credit_q;
    logic [PRICE_W-1:0] price_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [NUM_CH-1:0]  motor_en_q;
    logic               done_q;
    logic               fail_q;
    logic [1:0]         fail_code_q;
    logic [PRICE_W-1:0] charge_q;

    logic [STOCK_W-1:0] check_stock_s;
    logic               sold_out_s;
    logic               poor_s;
    logic               reject_s;
    logic               dec_s;
    logic [1:0]         code_s;

    stock_bank #(
        .INIT_STOCK(INIT_STOCK)
    ) u_stock_bank (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_s),
        .dec_channel    (ch_q),
        .restock_valid  (restock_valid),
        .restock_channel(restock_channel),
        .restock_qty    (restock_qty),
        .query_channel  (query_channel),
        .check_channel  (ch_q),
        .query_stock    (query_stock),
        .check_stock    (check_stock_s)
    );

    assign sold_out_s = (check_stock_s == {STOCK_W{1'b0}});
    assign poor_s     = (credit_q < price_q);
    assign reject_s   = sold_out_s || poor_s;
    assign dec_s      = (state_q == ST_CHECK) && !reject_s;

    // Map the two rejection reasons onto the reported code.
    always_comb begin
        code_s = FAIL_NONE;
        case ({poor_s, sold_out_s})
            2'b01:   code_s = FAIL_SOLD_OUT;
            2'b10:   code_s = FAIL_NO_CREDIT;
            2'b11:   code_s = FAIL_BOTH;
            default: code_s = FAIL_NONE;
        endcase
    end

    // Request FSM with motor down-counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= {CH_W{1'b0}};
            credit_q    <= {PRICE_W{1'b0}};
            price_q     <= {PRICE_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            motor_en_q  <= {NUM_CH{1'b0}};
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= FAIL_NONE;
            charge_q    <= {PRICE_W{1'b0}};
        end else begin
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= FAIL_NONE;
            case (state_q)
                ST_IDLE: begin
                    if (buy_valid) begin
                        ch_q     <= buy_channel;
                        credit_q <= credit;
                        price_q  <= PRICES[{buy_channel, 3'b000} +: PRICE_W];
                        busy_q   <= 1'b1;
                        state_q  <= ST_CHECK;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (reject_s) begin
                        fail_q      <= 1'b1;
                        fail_code_q <= code_s;
                        state_q     <= ST_REPORT_FAIL;
                    end else begin
                        motor_en_q  <= onehot(ch_q);
                        cnt_q       <= CNT_W'(MOTOR_CYCLES - 1);
                        state_q     <= ST_DISPENSE;
                    end
                end
                ST_DISPENSE: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        motor_en_q <= {NUM_CH{1'b0}};
                        done_q     <= 1'b1;
                        charge_q   <= price_q;
                        state_q    <= ST_REPORT_DONE;
                    end else begin
                        cnt_q      <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_REPORT_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_REPORT_FAIL: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q     <= 1'b0;
                    motor_en_q <= {NUM_CH{1'b0}};
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign motor_en  = motor_en_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign charge    = charge_q;

endmodule

// File: tb/tb_channel_dispenser.sv
// Directed bench for channel_dispenser: hand-computed expectations for sales,
// rejections, restock saturation, ignored buys and reset during a dispense.
module tb_channel_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       buy_valid;
    logic [2:0] buy_channel;
    logic [7:0] credit;
    logic       restock_valid;
    logic [2:0] restock_channel;
    logic [3:0] restock_qty;
    logic [2:0] query_channel;
    logic [3:0] query_stock;
    logic       busy;
    logic [7:0] motor_en;
    logic       done;
    logic       fail;
    logic [1:0] fail_code;
    logic [7:0] charge;

    int n_cmp = 0;
    int n_bad = 0;

    int         r_motor, r_bad_motor, r_first, r_done, r_done_cyc, r_fail, r_fail_cyc, r_code_bad;
    logic [1:0] r_code;
    logic       r_busy1, r_busy_end;

    channel_dispenser dut (
        .clk            (clk),
        .rst            (rst),
        .buy_valid      (buy_valid),
        .buy_channel    (buy_channel),
        .credit         (credit),
        .restock_valid  (restock_valid),
        .restock_channel(restock_channel),
        .restock_qty    (restock_qty),
        .query_channel  (query_channel),
        .query_stock    (query_stock),
        .busy           (busy),
        .motor_en       (motor_en),
        .done           (done),
        .fail           (fail),
        .fail_code      (fail_code),
        .charge         (charge)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stock(input string tag, input logic [2:0] ch, input logic [3:0] exp);
        @(negedge clk);
        query_channel = ch;
        #1;
        check_val(tag, {28'd0, query_stock}, {28'd0, exp});
    endtask

    // Buy is high in cycle 0; cycles 1..24 are sampled at the falling edge.
    task automatic run_buy(input logic [2:0] ch, input logic [7:0] cr,
                           input int xb_cyc, input logic [2:0] xb_ch,
                           input int rs_cyc, input logic [2:0] rs_ch, input logic [3:0] rs_qty,
                           input int rst_cyc);
        logic [7:0] oh;
        oh = 8'h01 << ch;
        r_motor = 0; r_bad_motor = 0; r_first = -1; r_done = 0; r_done_cyc = -1;
        r_fail = 0; r_fail_cyc = -1; r_code_bad = 0; r_code = 2'b00;
        r_busy1 = 1'b0; r_busy_end = 1'b1;
        @(posedge clk); #1;
        buy_channel = ch;
        credit      = cr;
        buy_valid   = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            buy_valid = (k == xb_cyc);
            if (k == xb_cyc) buy_channel = xb_ch;
            restock_valid   = (k == rs_cyc);
            restock_channel = rs_ch;
            restock_qty     = rs_qty;
            rst             = (k == rst_cyc);
            if (k == rst_cyc) begin
                #1;
                check_val("motor_off_at_reset", {24'd0, motor_en}, 32'd0);
            end
            @(negedge clk);
            if (motor_en == oh) begin
                r_motor++;
                if (r_first < 0) r_first = k;
            end else if (motor_en != 8'h00) begin
                r_bad_motor++;
            end
            if (done) begin r_done++; r_done_cyc = k; end
            if (fail) begin
                r_fail++; r_fail_cyc = k; r_code = fail_code;
            end else if (fail_code != 2'b00) begin
                r_code_bad++;
            end
            if (k == 1)  r_busy1    = busy;
            if (k == 24) r_busy_end = busy;
        end
        buy_valid     = 1'b0;
        restock_valid = 1'b0;
        rst           = 1'b0;
    endtask

    initial begin
        rst = 1'b1; buy_valid = 1'b0; buy_channel = 3'd0; credit = 8'd0;
        restock_valid = 1'b0; restock_channel = 3'd0; restock_qty = 4'd0; query_channel = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy",      {31'd0, busy},      32'd0);
        check_val("rst_motor",     {24'd0, motor_en},  32'd0);
        check_val("rst_done",      {31'd0, done},      32'd0);
        check_val("rst_fail",      {31'd0, fail},      32'd0);
        check_val("rst_fail_code", {30'd0, fail_code}, 32'd0);
        check_val("rst_charge",    {24'd0, charge},    32'd0);
        rst = 1'b0;
        check_stock("rst_stock3", 3'd3, 4'd5);

        // ch3 with enough credit; a ch1 buy lands mid-dispense and must be dropped
        run_buy(3'd3, 8'd10, 5, 3'd1, -1, 3'd0, 4'd0, -1);
        check_val("ch3_motor_cycles", r_motor,      32'd16);
        check_val("ch3_motor_first",  r_first,      32'd2);
        check_val("ch3_motor_other",  r_bad_motor,  32'd0);
        check_val("ch3_done_count",   r_done,       32'd1);
        check_val("ch3_done_cycle",   r_done_cyc,   32'd18);
        check_val("ch3_fail_count",   r_fail,       32'd0);
        check_val("ch3_busy_cycle1",  {31'd0, r_busy1},    32'd1);
        check_val("ch3_busy_end",     {31'd0, r_busy_end}, 32'd0);
        check_val("ch3_code_idle",    r_code_bad,   32'd0);
        check_val("ch3_charge",       {24'd0, charge}, 32'd4);
        check_stock("ch3_stock_after", 3'd3, 4'd4);
        check_stock("ch1_stock_kept",  3'd1, 4'd5);

        // ch7 costs 8, credit 7
        run_buy(3'd7, 8'd7, -1, 3'd0, -1, 3'd0, 4'd0, -1);
        check_val("ch7_fail_count", r_fail,     32'd1);
        check_val("ch7_fail_cycle", r_fail_cyc, 32'd2);
        check_val("ch7_fail_code",  {30'd0, r_code}, 32'd2);
        check_val("ch7_motor",      r_motor + r_bad_motor, 32'd0);
        check_val("ch7_done_count", r_done,     32'd0);
        check_val("ch7_charge_held", {24'd0, charge}, 32'd4);
        check_stock("ch7_stock_kept", 3'd7, 4'd5);

        // drain ch0 (price 1) with exact credit
        for (int i = 0; i < 5; i++) begin
            run_buy(3'd0, 8'd1, -1, 3'd0, -1, 3'd0, 4'd0, -1);
            check_val("ch0_drain_done", r_done, 32'd1);
        end
        check_val("ch0_charge", {24'd0, charge}, 32'd1);
        check_stock("ch0_stock_empty", 3'd0, 4'd0);
        run_buy(3'd0, 8'd1, -1, 3'd0, -1, 3'd0, 4'd0, -1);
        check_val("ch0_soldout_fail", r_fail, 32'd1);
        check_val("ch0_soldout_code", {30'd0, r_code}, 32'd1);
        run_buy(3'd0, 8'd0, -1, 3'd0, -1, 3'd0, 4'd0, -1);
        check_val("ch0_both_fail", r_fail, 32'd1);
        check_val("ch0_both_code", {30'd0, r_code}, 32'd3);

        // 5 + 15 saturates at 15
        @(posedge clk); #1;
        restock_valid = 1'b1; restock_channel = 3'd2; restock_qty = 4'd15;
        @(posedge clk); #1;
        restock_valid = 1'b0;
        check_stock("ch2_restock_sat", 3'd2, 4'd15);

        // reset in cycle 5 of a ch3 dispense
        run_buy(3'd3, 8'd10, -1, 3'd0, -1, 3'd0, 4'd0, 5);
        check_val("rstmid_done",  r_done,  32'd0);
        check_val("rstmid_motor", r_motor, 32'd3);
        for (int c = 0; c < 8; c++) begin
            check_stock($sformatf("rstmid_stock%0d", c), 3'(c), 4'd5);
        end

        // restock +2 during the CHECK cycle of a ch3 buy: 5 - 1 + 2
        run_buy(3'd3, 8'd10, -1, 3'd0, 1, 3'd3, 4'd2, -1);
        check_val("ch3_rs_done", r_done, 32'd1);
        check_stock("ch3_rs_stock", 3'd3, 4'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
